// File: rtl/imm_decode_pipe_if.sv
// ---------------------------------------------------------------------------
// imm_decode_pipe_if
// Purpose : bundles the upstream (fetch-queue) and downstream (register-read)
//           valid/ready handshakes of the immediate decoder into one bus.
// Signals :
//   in_valid / in_ready   upstream handshake
//   in_instr [31:0]       raw instruction word
//   in_tag   [TAG_W-1:0]  opaque sideband (PC), carried unmodified
//   out_valid / out_ready downstream handshake
//   out_imm  [XLEN-1:0]   sign-extended immediate
//   out_fmt  [2:0]        0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 CSR
//   out_tag  [TAG_W-1:0]  tag of the presented entry
// Modports: master = the side that drives instructions and accepts results,
//           slave  = the decoder itself.
// ---------------------------------------------------------------------------
interface imm_decode_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  out_imm;
  logic [2:0]       out_fmt;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_instr, in_tag, out_ready,
    input  in_ready, out_valid, out_imm, out_fmt, out_tag
  );

  modport slave (
    input  in_valid, in_instr, in_tag, out_ready,
    output in_ready, out_valid, out_imm, out_fmt, out_tag
  );
endinterface

// File: rtl/imm_decode_pipe.sv
// ---------------------------------------------------------------------------
// imm_decode_pipe
// Purpose : pipelined RV immediate decoder for the decode stage. Decodes the
//           immediate combinationally from the incoming instruction and
//           registers it, so a result appears one cycle after acceptance.
//           A main register plus a skid register give full throughput under
//           back-pressure while keeping in_ready a pure register output.
// Ports   :
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   flush  drops every buffered entry (and any same-cycle accept)
//   bus    imm_decode_pipe_if.slave : in_* handshake/data, out_* handshake/data
// Parameters:
//   XLEN   32 or 64, width of the sign-extended immediate
//   TAG_W  width of the sideband tag
// Build option:
//   IMM_DECODE_ZICSR_EN  when defined, CSRRWI/CSRRSI/CSRRCI produce format CSR
//                        with the zero-extended 5-bit uimm as the immediate.
// ---------------------------------------------------------------------------
module imm_decode_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  imm_decode_pipe_if.slave bus
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
`ifdef IMM_DECODE_ZICSR_EN
  localparam logic [2:0] FMT_CSR  = 3'd6;
`endif

  localparam logic [6:0] OP_IMM  = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
`ifdef IMM_DECODE_ZICSR_EN
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
`endif

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_t;

  state_t           state_q;
  logic             outValid_q;
  logic             inReady_q;
  logic [XLEN-1:0]  mainImm_q;
  logic [2:0]       mainFmt_q;
  logic [TAG_W-1:0] mainTag_q;
  logic [XLEN-1:0]  skidImm_q;
  logic [2:0]       skidFmt_q;
  logic [TAG_W-1:0] skidTag_q;

  logic [31:0]      imm32;
  logic [XLEN-1:0]  decImm_d;
  logic [2:0]       decFmt_d;
  logic             accept;
  logic             pop;

  // Immediate assembly on a 32-bit value first; every format's top bit sits
  // at bit 31 (the CSR uimm is zero there), so a single signed widening to
  // XLEN covers both the sign-extended and zero-extended cases.
  always_comb begin
    imm32    = '0;
    decFmt_d = FMT_NONE;
    case (bus.in_instr[6:0])
      OP_IMM, OP_JALR, OP_LOAD: begin
        decFmt_d = FMT_I;
        imm32    = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      end
      OP_STORE: begin
        decFmt_d = FMT_S;
        imm32    = {{20{bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
      end
      OP_BRANCH: begin
        decFmt_d = FMT_B;
        imm32    = {{19{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[7],
                    bus.in_instr[30:25], bus.in_instr[11:8], 1'b0};
      end
      OP_JAL: begin
        decFmt_d = FMT_J;
        imm32    = {{11{bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                    bus.in_instr[20], bus.in_instr[30:21], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        decFmt_d = FMT_U;
        imm32    = {bus.in_instr[31:12], 12'b0};
      end
`ifdef IMM_DECODE_ZICSR_EN
      OP_SYSTEM: begin
        // Only the immediate CSR forms (funct3[2]=1) carry an immediate.
        if (bus.in_instr[14]) begin
          decFmt_d = FMT_CSR;
          imm32    = {27'b0, bus.in_instr[19:15]};
        end
      end
`endif
      default: begin
        decFmt_d = FMT_NONE;
        imm32    = '0;
      end
    endcase
  end

  assign decImm_d = XLEN'($signed(imm32));

  // Handshake qualifiers use only registered flags, so in_ready never depends
  // on in_valid and out_valid never depends on out_ready.
  assign accept = bus.in_valid & inReady_q;
  assign pop    = outValid_q & bus.out_ready;

  // Occupancy FSM with registered in_ready/out_valid. The main register always
  // holds the oldest entry; the skid register only fills when an entry is
  // accepted while the main one is stalled. Flush clears occupancy but leaves
  // the data registers untouched, so outputs hold while out_valid is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
      mainImm_q  <= '0;
      mainFmt_q  <= '0;
      mainTag_q  <= '0;
    end else if (flush) begin
      state_q    <= EMPTY;
      outValid_q <= 1'b0;
      inReady_q  <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            mainImm_q  <= decImm_d;
            mainFmt_q  <= decFmt_d;
            mainTag_q  <= bus.in_tag;
            outValid_q <= 1'b1;
            state_q    <= FULL1;
          end
        end
        FULL1: begin
          if (accept && !pop) begin
            skidImm_q <= decImm_d;
            skidFmt_q <= decFmt_d;
            skidTag_q <= bus.in_tag;
            inReady_q <= 1'b0;
            state_q   <= FULL2;
          end else if (accept && pop) begin
            mainImm_q <= decImm_d;
            mainFmt_q <= decFmt_d;
            mainTag_q <= bus.in_tag;
          end else if (pop) begin
            outValid_q <= 1'b0;
            state_q    <= EMPTY;
          end
        end
        FULL2: begin
          if (pop) begin
            mainImm_q <= skidImm_q;
            mainFmt_q <= skidFmt_q;
            mainTag_q <= skidTag_q;
            inReady_q <= 1'b1;
            state_q   <= FULL1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          outValid_q <= 1'b0;
          inReady_q  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = inReady_q;
  assign bus.out_valid = outValid_q;
  assign bus.out_imm   = mainImm_q;
  assign bus.out_fmt   = mainFmt_q;
  assign bus.out_tag   = mainTag_q;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// ---------------------------------------------------------------------------
// tb_imm_decode_pipe
// Drives an XLEN=32 and an XLEN=64 instance with identical stimulus and
// compares both against a queue-based reference model whose immediates are
// computed arithmetically from the instruction fields. Optional build macro:
// IMM_DECODE_ZICSR_EN (must match the RTL build).
// ---------------------------------------------------------------------------
module tb_imm_decode_pipe;

  localparam int TAG_W = 32;

  logic             clk = 1'b0;
  logic             rstN;
  logic             flush;
  logic             inValid;
  logic             outReady;
  logic [31:0]      inInstr;
  logic [TAG_W-1:0] inTag;

  always #5 clk = ~clk;

  imm_decode_pipe_if #(.XLEN(32), .TAG_W(TAG_W)) ifA ();
  imm_decode_pipe_if #(.XLEN(64), .TAG_W(TAG_W)) ifB ();

  assign ifA.in_valid  = inValid;
  assign ifA.in_instr  = inInstr;
  assign ifA.in_tag    = inTag;
  assign ifA.out_ready = outReady;
  assign ifB.in_valid  = inValid;
  assign ifB.in_instr  = inInstr;
  assign ifB.in_tag    = inTag;
  assign ifB.out_ready = outReady;

  imm_decode_pipe #(.XLEN(32), .TAG_W(TAG_W)) dutA (
    .clk(clk), .rst_n(rstN), .flush(flush), .bus(ifA.slave)
  );

  imm_decode_pipe #(.XLEN(64), .TAG_W(TAG_W)) dutB (
    .clk(clk), .rst_n(rstN), .flush(flush), .bus(ifB.slave)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [63:0] imm;
    logic [31:0] tag;
  } entry_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  expFmt;
    logic [63:0] expImm;
  } vec_t;

  entry_t modelQ[$];
  int checks = 0;
  int passed = 0;

  // Reference decode: immediates built as signed integers from field weights.
  function automatic void refDecode(input logic [31:0] ins, output logic [2:0] fmt,
                                    output logic [63:0] imm);
    longint v;
    v   = 0;
    fmt = 3'd0;
    case (ins[6:0])
      7'h13, 7'h67, 7'h03: begin
        fmt = 3'd1;
        v = longint'(ins[31:20]);
        if (v >= 2048) v = v - 4096;
      end
      7'h23: begin
        fmt = 3'd2;
        v = longint'(ins[31:25]) * 32 + longint'(ins[11:7]);
        if (v >= 2048) v = v - 4096;
      end
      7'h63: begin
        fmt = 3'd3;
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
        if (ins[31]) v = v - 4096;
      end
      7'h6F: begin
        fmt = 3'd5;
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
        if (ins[31]) v = v - 1048576;
      end
      7'h37, 7'h17: begin
        fmt = 3'd4;
        v = longint'(ins[31:12]) * 4096;
        if (ins[31]) v = v - 64'sh1_0000_0000;
      end
`ifdef IMM_DECODE_ZICSR_EN
      7'h73: begin
        if (ins[14]) begin
          fmt = 3'd6;
          v = longint'(ins[19:15]);
        end
      end
`endif
      default: begin
        fmt = 3'd0;
        v = 0;
      end
    endcase
    imm = 64'(v);
  endfunction

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Drive one cycle of inputs, advance the model at the rising edge, and
  // return at the falling edge where outputs are sampled.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [31:0] tag,
                               input logic ordy, input logic fl, input logic rn);
    bit     acc;
    bit     pp;
    entry_t e;
    inValid  = v;
    inInstr  = ins;
    inTag    = tag;
    outReady = ordy;
    flush    = fl;
    rstN     = rn;
    @(posedge clk);
    if (!rn || fl) begin
      modelQ.delete();
    end else begin
      acc = v && (modelQ.size() < 2);
      pp  = (modelQ.size() > 0) && ordy;
      if (pp) void'(modelQ.pop_front());
      if (acc) begin
        refDecode(ins, e.fmt, e.imm);
        e.tag = tag;
        modelQ.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic checkOutput();
    checkValue("A.out_valid", 64'(ifA.out_valid), 64'(modelQ.size() > 0));
    checkValue("B.out_valid", 64'(ifB.out_valid), 64'(modelQ.size() > 0));
    checkValue("A.in_ready", 64'(ifA.in_ready), 64'(modelQ.size() < 2));
    checkValue("B.in_ready", 64'(ifB.in_ready), 64'(modelQ.size() < 2));
    if (modelQ.size() > 0) begin
      checkValue("A.out_imm", 64'(ifA.out_imm), {32'b0, modelQ[0].imm[31:0]});
      checkValue("B.out_imm", 64'(ifB.out_imm), modelQ[0].imm);
      checkValue("A.out_fmt", 64'(ifA.out_fmt), 64'(modelQ[0].fmt));
      checkValue("B.out_fmt", 64'(ifB.out_fmt), 64'(modelQ[0].fmt));
      checkValue("A.out_tag", 64'(ifA.out_tag), 64'(modelQ[0].tag));
      checkValue("B.out_tag", 64'(ifB.out_tag), 64'(modelQ[0].tag));
    end
  endtask

  task automatic checkResetValues(input string where);
    checkValue({where, ".A.out_valid"}, 64'(ifA.out_valid), 64'd0);
    checkValue({where, ".A.in_ready"}, 64'(ifA.in_ready), 64'd1);
    checkValue({where, ".A.out_imm"}, 64'(ifA.out_imm), 64'd0);
    checkValue({where, ".B.out_imm"}, 64'(ifB.out_imm), 64'd0);
    checkValue({where, ".A.out_fmt"}, 64'(ifA.out_fmt), 64'd0);
    checkValue({where, ".B.out_fmt"}, 64'(ifB.out_fmt), 64'd0);
    checkValue({where, ".A.out_tag"}, 64'(ifA.out_tag), 64'd0);
    checkValue({where, ".B.out_tag"}, 64'(ifB.out_tag), 64'd0);
  endtask

  initial begin
    vec_t       vecs[10];
    logic [6:0] opList[11];
    logic [31:0] r;
    logic [31:0] ins;

    vecs[0] = '{32'hFFF00093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF};
    vecs[1] = '{32'hFE112E23, 3'd2, 64'hFFFF_FFFF_FFFF_FFFC};
    vecs[2] = '{32'hFE000CE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFF8};
    vecs[3] = '{32'h001000EF, 3'd5, 64'h0000_0000_0000_0800};
    vecs[4] = '{32'h123452B7, 3'd4, 64'h0000_0000_1234_5000};
    vecs[5] = '{32'h800002B7, 3'd4, 64'hFFFF_FFFF_8000_0000};
    vecs[6] = '{32'h00000033, 3'd0, 64'h0};
    vecs[7] = '{32'h0040A103, 3'd1, 64'h4};
    vecs[8] = '{32'h00000073, 3'd0, 64'h0};
`ifdef IMM_DECODE_ZICSR_EN
    vecs[9] = '{32'h3002D073, 3'd6, 64'h5};
`else
    vecs[9] = '{32'h3002D073, 3'd0, 64'h0};
`endif

    opList = '{7'h13, 7'h67, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33, 7'h73, 7'h0F};

    // Reset and reset-value check
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    checkResetValues("reset");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput();

    // Directed table, back-to-back with out_ready held high
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, vecs[i].instr, 32'h1000 + 32'(i), 1'b1, 1'b0, 1'b1);
      checkOutput();
      checkValue($sformatf("vec%0d.B.imm", i), 64'(ifB.out_imm), vecs[i].expImm);
      checkValue($sformatf("vec%0d.A.imm", i), 64'(ifA.out_imm), {32'b0, vecs[i].expImm[31:0]});
      checkValue($sformatf("vec%0d.fmt", i), 64'(ifB.out_fmt), 64'(vecs[i].expFmt));
      checkValue($sformatf("vec%0d.tag", i), 64'(ifA.out_tag), 64'h1000 + 64'(i));
      checkValue($sformatf("vec%0d.valid", i), 64'(ifA.out_valid), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput();

    // Back-pressure: three offers with out_ready low, only two accepted
    applyStimulus(1'b1, vecs[0].instr, 32'hA0, 1'b0, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(1'b1, vecs[1].instr, 32'hA1, 1'b0, 1'b0, 1'b1);
    checkOutput();
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, vecs[2].instr, 32'hA2, 1'b0, 1'b0, 1'b1);
      checkOutput();
      checkValue("bp.in_ready", 64'(ifA.in_ready), 64'd0);
      checkValue("bp.hold_tag", 64'(ifA.out_tag), 64'hA0);
    end
    applyStimulus(1'b1, vecs[2].instr, 32'hA2, 1'b1, 1'b0, 1'b1);
    checkOutput();
    checkValue("bp.second_tag", 64'(ifA.out_tag), 64'hA1);
    applyStimulus(1'b1, vecs[2].instr, 32'hA2, 1'b1, 1'b0, 1'b1);
    checkOutput();
    checkValue("bp.third_tag", 64'(ifA.out_tag), 64'hA2);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput();

    // Flush from FULL2 with a same-cycle offer
    applyStimulus(1'b1, vecs[3].instr, 32'hB0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, vecs[4].instr, 32'hB1, 1'b0, 1'b0, 1'b1);
    checkOutput();
    applyStimulus(1'b1, vecs[5].instr, 32'hB2, 1'b0, 1'b1, 1'b1);
    checkOutput();
    checkValue("flush.out_valid", 64'(ifB.out_valid), 64'd0);
    checkValue("flush.in_ready", 64'(ifB.in_ready), 64'd1);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput();
    checkValue("flush.nothing", 64'(ifB.out_valid), 64'd0);

    // Reset mid-stream
    applyStimulus(1'b1, vecs[3].instr, 32'hC0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, vecs[4].instr, 32'hC1, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, vecs[5].instr, 32'hC2, 1'b1, 1'b1, 1'b0);
    checkResetValues("midreset");
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    checkOutput();

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      logic v, ordy, fl, rn;
      r   = $urandom();
      ins = {r[31:7], opList[$urandom_range(0, 10)]};
      if ($urandom_range(0, 9) == 0) ins[6:0] = 7'($urandom());
      v    = ($urandom_range(0, 3) != 0);
      ordy = (c % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      fl   = ($urandom_range(0, 63) == 0);
      rn   = ($urandom_range(0, 199) != 0);
      applyStimulus(v, ins, $urandom(), ordy, fl, rn);
      checkOutput();
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
